// File: rtl/hybrid_pwm_sd_pkg.sv
// Shared constants and types for the hybrid PWM/sigma-delta demodulator.
// Scaling defaults match the modulator, so both sides stay in step.
package hybrid_pwm_sd_pkg;

  localparam int FRAME_BITS = 5;
  localparam int FRAME_LEN  = 32;

  // round(65536/30): the modulator spends 30 of the 32 frame cycles on signal.
  localparam int DEF_GAIN = 2185;
  // High cycles per frame that encode sample 0.
  localparam int DEF_HMIN = 2;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_t;

  // Clamp a signed intermediate into the unsigned 16-bit sample range.
  function automatic logic [15:0] sat_u16(input logic signed [31:0] v);
    logic [15:0] r;
    if (v < 0) begin
      r = 16'd0;
    end else if (v > 32'sd65535) begin
      r = 16'hFFFF;
    end else begin
      r = v[15:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/hybrid_pwm_sd_framer.sv
// Frame framer: finds rising edges, keeps the 32-cycle frame grid, counts the
// high cycles in each frame and runs the HUNT/ACQ/LOCK state machine.
// r_timer always holds the frame position of the cycle being sampled now.
module hybrid_pwm_sd_framer
  import hybrid_pwm_sd_pkg::*;
#(
  parameter int LOCK_FRAMES = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_din,
  output logic [FRAME_BITS:0] o_hw,
  output logic                o_hw_valid,
  output logic                o_lock_frame,
  output logic                o_frame_err,
  output logic [1:0]          o_state
);

  localparam logic [FRAME_BITS-1:0] LAST_POS  = FRAME_BITS'(FRAME_LEN - 1);
  localparam logic [3:0]            GOOD_LAST = 4'(LOCK_FRAMES - 1);

  state_t                r_state;
  logic                  r_din_prev;
  logic [FRAME_BITS-1:0] r_timer;
  logic [FRAME_BITS:0]   r_hcnt;
  logic [3:0]            r_good;
  logic [FRAME_BITS:0]   r_hw;
  logic                  r_hw_valid;
  logic                  r_lock_frame;
  logic                  r_frame_err;

  state_t                w_state_nxt;
  logic [FRAME_BITS-1:0] w_timer_nxt;
  logic [FRAME_BITS:0]   w_hcnt_nxt;
  logic [3:0]            w_good_nxt;
  logic [FRAME_BITS:0]   w_hw_nxt;
  logic                  w_hw_valid_nxt;
  logic                  w_lock_frame_nxt;
  logic                  w_frame_err_nxt;
  logic                  w_edge;
  logic [FRAME_BITS:0]   w_din_ext;

  assign w_edge    = i_din & ~r_din_prev;
  assign w_din_ext = {{FRAME_BITS{1'b0}}, i_din};

  // Next-state and frame bookkeeping; an edge cycle is position 0, so the
  // register is loaded with 1 for the cycle after it.
  always_comb begin
    w_state_nxt      = r_state;
    w_timer_nxt      = r_timer;
    w_hcnt_nxt       = r_hcnt;
    w_good_nxt       = r_good;
    w_hw_nxt         = r_hw;
    w_hw_valid_nxt   = 1'b0;
    w_lock_frame_nxt = 1'b0;
    w_frame_err_nxt  = 1'b0;
    case (r_state)
      HUNT: begin
        if (w_edge) begin
          w_state_nxt = ACQ;
          w_timer_nxt = FRAME_BITS'(1);
          w_hcnt_nxt  = (FRAME_BITS+1)'(1);
          w_good_nxt  = 4'd0;
        end
      end
      ACQ, LOCK: begin
        if (w_edge && (r_timer != '0)) begin
          // Misplaced edge: drop the partial frame and re-acquire from here.
          w_frame_err_nxt = 1'b1;
          w_state_nxt     = ACQ;
          w_timer_nxt     = FRAME_BITS'(1);
          w_hcnt_nxt      = (FRAME_BITS+1)'(1);
          w_good_nxt      = 4'd0;
        end else begin
          w_timer_nxt = r_timer + FRAME_BITS'(1);
          if (r_timer == LAST_POS) begin
            w_hw_nxt       = r_hcnt + w_din_ext;
            w_hw_valid_nxt = 1'b1;
            w_hcnt_nxt     = '0;
            if (r_state == LOCK) begin
              w_lock_frame_nxt = 1'b1;
            end else if (r_good == GOOD_LAST) begin
              w_state_nxt = LOCK;
              w_good_nxt  = 4'd0;
            end else begin
              w_good_nxt = r_good + 4'd1;
            end
          end else begin
            w_hcnt_nxt = r_hcnt + w_din_ext;
          end
        end
      end
      default: begin
        w_state_nxt = HUNT;
      end
    endcase
  end

  // State and output registers; reset discards any partial frame.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= HUNT;
      r_din_prev   <= 1'b0;
      r_timer      <= '0;
      r_hcnt       <= '0;
      r_good       <= 4'd0;
      r_hw         <= '0;
      r_hw_valid   <= 1'b0;
      r_lock_frame <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_din_prev   <= i_din;
      r_timer      <= w_timer_nxt;
      r_hcnt       <= w_hcnt_nxt;
      r_good       <= w_good_nxt;
      r_hw         <= w_hw_nxt;
      r_hw_valid   <= w_hw_valid_nxt;
      r_lock_frame <= w_lock_frame_nxt;
      r_frame_err  <= w_frame_err_nxt;
    end
  end

  assign o_hw         = r_hw;
  assign o_hw_valid   = r_hw_valid;
  assign o_lock_frame = r_lock_frame;
  assign o_frame_err  = r_frame_err;
  assign o_state      = r_state;

endmodule

// File: rtl/hybrid_pwm_sd_dec.sv
// Hybrid PWM/sigma-delta demodulator top: framer plus a boxcar decimator
// that removes the HMIN offset, applies the gain and saturates to 16 bits.
module hybrid_pwm_sd_dec
  import hybrid_pwm_sd_pkg::*;
#(
  parameter int DECIM_LOG2  = 4,
  parameter int LOCK_FRAMES = 2,
  parameter int GAIN        = DEF_GAIN,
  parameter int HMIN        = DEF_HMIN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din,
  output logic [15:0] dout,
  output logic        dout_valid,
  output logic [5:0]  hw,
  output logic        hw_valid,
  output logic        locked,
  output logic        frame_err
);

  localparam int          N      = 1 << DECIM_LOG2;
  localparam int          OFFSET = HMIN * N;
  localparam logic [8:0]  CNT_LAST = 9'(N - 1);

  logic [5:0]         w_hw;
  logic               w_hw_valid;
  logic               w_lock_frame;
  logic               w_frame_err;
  logic [1:0]         w_state;
  logic [13:0]        w_sum;
  logic signed [31:0] w_diff;
  logic signed [31:0] w_prod;
  logic signed [31:0] w_scaled;
  logic [15:0]        w_sample;

  logic [13:0] r_acc;
  logic [8:0]  r_cnt;
  logic [15:0] r_dout;
  logic        r_dout_valid;

  hybrid_pwm_sd_framer #(
    .LOCK_FRAMES (LOCK_FRAMES)
  ) u_framer (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_din        (din),
    .o_hw         (w_hw),
    .o_hw_valid   (w_hw_valid),
    .o_lock_frame (w_lock_frame),
    .o_frame_err  (w_frame_err),
    .o_state      (w_state)
  );

  // Scale the running sum including the frame just completed.
  always_comb begin
    w_sum    = r_acc + {8'd0, w_hw};
    w_diff   = $signed({18'd0, w_sum}) - OFFSET;
    w_prod   = w_diff * GAIN;
    w_scaled = w_prod >>> DECIM_LOG2;
    w_sample = sat_u16(w_scaled);
  end

  // Decimator: only frames that lie fully inside LOCK are summed; any loss
  // of lock empties the accumulator. dout holds until the next strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc        <= 14'd0;
      r_cnt        <= 9'd0;
      r_dout       <= 16'd0;
      r_dout_valid <= 1'b0;
    end else begin
      r_dout_valid <= 1'b0;
      if (w_frame_err || (w_state != LOCK)) begin
        r_acc <= 14'd0;
        r_cnt <= 9'd0;
      end else if (w_lock_frame) begin
        if (r_cnt == CNT_LAST) begin
          r_acc        <= 14'd0;
          r_cnt        <= 9'd0;
          r_dout       <= w_sample;
          r_dout_valid <= 1'b1;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + 9'd1;
        end
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign hw         = w_hw;
  assign hw_valid   = w_hw_valid;
  assign locked     = (w_state == LOCK);
  assign frame_err  = w_frame_err;

endmodule
